// File: rtl/timer_counter.sv
// timer_counter: memory-mapped countdown timer on the CPU data-memory port.
//
// Register window (16 bytes at BASE_ADDR):
//   +0 CTRL   [0] EN, [2:1] MODE, [3] IM; upper bits read 0
//   +4 PRESET reload value, byte-writable
//   +8 COUNT  current count, read-only
//   +C        reads 0, writes ignored
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-low reset
//   addr    byte address from the CPU M stage
//   byteen  byte write enables; nonzero marks a write
//   wdata   lane-aligned write data
//   rdata   combinational read data for addr (0 outside the window)
//   irq     interrupt request = IM & expiry flag
//
// Build option: define TC_AUTO_RELOAD_EN to enable MODE=01 auto-reload.
// Without it MODE is not stored (reads 0) and every expiry is one-shot.
module timer_counter #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;

    state_t      state, state_nxt;
    logic        en, im;
    logic [1:0]  mode;
    logic [31:0] preset, count;
    logic        irq_flag;
    logic        auto_reload;

    logic hit, wr, wr_ctrl, wr_preset;
    logic do_load, do_dec, do_int;

    assign hit       = (addr[31:4] == BASE_ADDR[31:4]) && (addr[3:2] != 2'b11);
    assign wr        = hit && (byteen != 4'b0000);
    assign wr_ctrl   = wr && (addr[3:2] == 2'b00);
    assign wr_preset = wr && (addr[3:2] == 2'b01);

    // Byte lanes within a word are selected by byteen, not addr[1:0].
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^addr[1:0];

`ifdef TC_AUTO_RELOAD_EN
    assign auto_reload = (mode == 2'b01);
`else
    assign auto_reload = 1'b0;
    assign mode        = 2'b00;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state and per-state actions
    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_dec    = 1'b0;
        do_int    = 1'b0;
        case (state)
            S_IDLE: if (en) state_nxt = S_LOAD;
            S_LOAD: begin
                do_load   = 1'b1;
                state_nxt = S_CNT;
            end
            S_CNT: begin
                if (!en)                 state_nxt = S_IDLE;
                else if (count == 32'd0) state_nxt = S_INT;
                else                     do_dec    = 1'b1;
            end
            S_INT: begin
                do_int    = 1'b1;
                state_nxt = auto_reload ? S_LOAD : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // CTRL: a CPU write in the INT cycle wins over the one-shot EN clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en <= 1'b0;
            im <= 1'b0;
        end else if (wr_ctrl && byteen[0]) begin
            en <= wdata[0];
            im <= wdata[3];
        end else if (do_int && !auto_reload) begin
            en <= 1'b0;
        end
    end

`ifdef TC_AUTO_RELOAD_EN
    logic flag_pulse;  // irq_flag was set by an auto-reload expiry last cycle

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                     mode <= 2'b00;
        else if (wr_ctrl && byteen[0])  mode <= wdata[2:1];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) flag_pulse <= 1'b0;
        else        flag_pulse <= do_int && auto_reload;
    end
`endif

    // PRESET: byte-lane writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset <= 32'd0;
        end else if (wr_preset) begin
            for (int b = 0; b < 4; b++)
                if (byteen[b]) preset[8*b +: 8] <= wdata[8*b +: 8];
        end
    end

    // COUNT: decrement only happens when nonzero, so it never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       count <= 32'd0;
        else if (do_load) count <= preset;
        else if (do_dec)  count <= count - 32'd1;
    end

    // Expiry flag: setting on INT takes priority over the write clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                      irq_flag <= 1'b0;
        else if (do_int)                 irq_flag <= 1'b1;
        else if (wr_ctrl || wr_preset)   irq_flag <= 1'b0;
`ifdef TC_AUTO_RELOAD_EN
        else if (flag_pulse)             irq_flag <= 1'b0;
`endif
    end

    assign irq = im & irq_flag;

    always_comb begin
        rdata = 32'd0;
        if (hit) begin
            case (addr[3:2])
                2'b00:   rdata = {28'd0, im, mode, en};
                2'b01:   rdata = preset;
                2'b10:   rdata = count;
                default: rdata = 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;

    localparam logic [31:0] BASE = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL   = BASE;
    localparam logic [31:0] A_PRESET = BASE + 32'd4;
    localparam logic [31:0] A_COUNT  = BASE + 32'd8;
    localparam logic [31:0] A_RSVD   = BASE + 32'd12;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  byteen = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int failures = 0;

    timer_counter #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .addr(addr), .byteen(byteen),
        .wdata(wdata), .rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Write lands on the next rising edge; returns 1ns after it.
    task automatic wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        addr = a; byteen = be; wdata = d;
        tick();
        byteen = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        addr = a; byteen = 4'b0000;
        #1;
        d = rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b0;
        ticks(2);
        rd(A_CTRL, d);   checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_ctrl got=%h exp=0", d); end
        rd(A_PRESET, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_preset got=%h exp=0", d); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        reset = 1'b1;
        tick();
        // Mid-count reset: PRESET=10, COUNT reaches 5 seven edges after EN.
        wr(A_PRESET, 4'hF, 32'd10);
        wr(A_CTRL, 4'hF, 32'h9);
        ticks(7);
        rd(A_COUNT, d);  checks++; if (d !== 32'd5) begin failures++; $display("FAIL midcount_pre got=%0d exp=5", d); end
        reset = 1'b0;
        rd(A_CTRL, d);   checks++; if (d !== 32'd0) begin failures++; $display("FAIL midreset_ctrl got=%h exp=0", d); end
        rd(A_PRESET, d); checks++; if (d !== 32'd0) begin failures++; $display("FAIL midreset_preset got=%h exp=0", d); end
        rd(A_COUNT, d);  checks++; if (d !== 32'd0) begin failures++; $display("FAIL midreset_count got=%h exp=0", d); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL midreset_irq got=%b exp=0", irq); end
        reset = 1'b1;
        ticks(4);
        rd(A_COUNT, d);  checks++; if (d !== 32'd0) begin failures++; $display("FAIL postreset_idle_count got=%h exp=0", d); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL postreset_irq got=%b exp=0", irq); end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        wr(A_PRESET, 4'hF, 32'd3);
        wr(A_CTRL, 4'hF, 32'h9);            // edge t0
        ticks(2);                           // t2
        for (int k = 0; k < 4; k++) begin   // COUNT 3,2,1,0 after t2..t5
            rd(A_COUNT, d);
            checks++; if (d !== 32'(3 - k)) begin failures++; $display("FAIL oneshot_count[%0d] got=%0d exp=%0d", k, d, 3 - k); end
            checks++; if (irq !== 1'b0) begin failures++; $display("FAIL oneshot_irq_early[%0d] got=%b exp=0", k, irq); end
            tick();
        end
        // now just after t6 (INT edge): irq not yet
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL oneshot_irq_t6 got=%b exp=0", irq); end
        tick();                             // t7
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL oneshot_irq_t7 got=%b exp=1", irq); end
        ticks(3);
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL oneshot_irq_hold got=%b exp=1", irq); end
        rd(A_CTRL, d);
        checks++; if (d !== 32'h8) begin failures++; $display("FAIL oneshot_ctrl got=%h exp=8", d); end
        wr(A_CTRL, 4'hF, 32'h0);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL oneshot_irq_clear got=%b exp=0", irq); end
    endtask

    task automatic test_byteen();
        logic [31:0] d;
        wr(A_PRESET, 4'hF, 32'h0);
        wr(A_PRESET, 4'b0100, 32'h00AB_0000);
        rd(A_PRESET, d);
        checks++; if (d !== 32'h00AB_0000) begin failures++; $display("FAIL byteen_lane2 got=%h exp=00ab0000", d); end
        wr(A_PRESET, 4'b0001, 32'hFFFF_FFCD);
        rd(A_PRESET, d);
        checks++; if (d !== 32'h00AB_00CD) begin failures++; $display("FAIL byteen_lane0 got=%h exp=00ab00cd", d); end
        wr(A_COUNT, 4'hF, 32'hDEAD_BEEF);
        rd(A_COUNT, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL count_readonly got=%h exp=0", d); end
        wr(A_RSVD, 4'hF, 32'hFFFF_FFFF);
        rd(A_RSVD, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL rsvd_read got=%h exp=0", d); end
        // Upper CTRL bytes are not stored.
        wr(A_CTRL, 4'b1110, 32'hFFFF_FF00);
        rd(A_CTRL, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL ctrl_upper got=%h exp=0", d); end
    endtask

    task automatic test_auto_reload();
        logic [31:0] d;
        logic exp;
        wr(A_PRESET, 4'hF, 32'd2);
        wr(A_CTRL, 4'hF, 32'hB);            // edge t0
        for (int i = 1; i <= 17; i++) begin
            tick();
`ifdef TC_AUTO_RELOAD_EN
            exp = (i == 6) || (i == 11) || (i == 16);
`else
            exp = (i >= 6);
`endif
            checks++; if (irq !== exp) begin failures++; $display("FAIL auto_irq_t%0d got=%b exp=%b", i, irq, exp); end
        end
        rd(A_CTRL, d);
`ifdef TC_AUTO_RELOAD_EN
        checks++; if (d !== 32'hB) begin failures++; $display("FAIL auto_ctrl got=%h exp=b", d); end
`else
        checks++; if (d !== 32'h8) begin failures++; $display("FAIL auto_ctrl got=%h exp=8", d); end
`endif
        wr(A_CTRL, 4'hF, 32'h0);
        ticks(8);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL auto_stop_irq got=%b exp=0", irq); end
    endtask

    task automatic test_mask();
        logic [31:0] d;
        wr(A_PRESET, 4'hF, 32'd1);
        wr(A_CTRL, 4'hF, 32'h1);            // EN, IM=0; expiry flag at t5
        ticks(7);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mask_irq got=%b exp=0", irq); end
        rd(A_CTRL, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL mask_ctrl got=%h exp=0", d); end
        wr(A_CTRL, 4'hF, 32'h8);
        tick();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mask_unmask_irq got=%b exp=0", irq); end
        wr(A_CTRL, 4'hF, 32'h0);
    endtask

    task automatic test_pause();
        logic [31:0] d;
        wr(A_PRESET, 4'hF, 32'd8);
        wr(A_CTRL, 4'hF, 32'h1);            // t0
        ticks(5);                           // t5: COUNT=5
        rd(A_COUNT, d);
        checks++; if (d !== 32'd5) begin failures++; $display("FAIL pause_pre got=%0d exp=5", d); end
        wr(A_CTRL, 4'hF, 32'h0);            // lands at t6: COUNT 4, then CNT exits
        rd(A_COUNT, d);
        checks++; if (d !== 32'd4) begin failures++; $display("FAIL pause_at got=%0d exp=4", d); end
        ticks(5);
        rd(A_COUNT, d);
        checks++; if (d !== 32'd4) begin failures++; $display("FAIL pause_hold got=%0d exp=4", d); end
    endtask

    task automatic test_nonhit();
        logic [31:0] d;
        wr(A_PRESET, 4'hF, 32'h55);
        wr(BASE + 32'd16, 4'hF, 32'hFFFF_FFFF);
        rd(BASE + 32'd16, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL nonhit_rdata got=%h exp=0", d); end
        rd(A_CTRL, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL nonhit_ctrl got=%h exp=0", d); end
        rd(A_PRESET, d);
        checks++; if (d !== 32'h55) begin failures++; $display("FAIL nonhit_preset got=%h exp=55", d); end
        tick();
        rd(A_COUNT, d);
        checks++; if (d !== 32'd4) begin failures++; $display("FAIL nonhit_count got=%h exp=4", d); end
    endtask

    // PRESET=0 expiry, plus a CTRL write landing in the INT cycle.
    task automatic test_back_to_back();
        logic [31:0] d;
        wr(A_PRESET, 4'hF, 32'd0);
        wr(A_CTRL, 4'hF, 32'h9);            // t0
        ticks(2);                           // t2: LOAD done, COUNT=0
        rd(A_COUNT, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL zero_count got=%h exp=0", d); end
        tick();                             // t3: entered INT
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL zero_irq_t3 got=%b exp=0", irq); end
        wr(A_CTRL, 4'hF, 32'h9);            // lands at t4, the INT edge
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL int_write_irq got=%b exp=1", irq); end
        rd(A_CTRL, d);
        checks++; if (d !== 32'h9) begin failures++; $display("FAIL int_write_ctrl got=%h exp=9", d); end
        wr(A_CTRL, 4'hF, 32'h0);
        ticks(6);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL b2b_stop_irq got=%b exp=0", irq); end
        rd(A_CTRL, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL b2b_stop_ctrl got=%h exp=0", d); end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_byteen();
        test_auto_reload();
        test_mask();
        test_pause();
        test_nonhit();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped countdown timer on the pipelined CPU's data-memory port, alongside data memory. It decodes the CPU's M-stage byte-enabled store/load bus (address, write data, 4-bit byte enable) against a three-word register window. It counts down from a programmed preset under a 4-state FSM and raises an interrupt request on expiry. Loads read back through a combinational data path merged with DM read data by the system bridge.

## Interface
- `BASE_ADDR`, default 32'h0000_7F00, word-aligned base of the 16-byte window; bits [3:0] must be 0.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `addr`  in  32  byte address from CPU M stage (`m_data_addr`).
- `byteen`  in  4  byte write enables (`m_data_byteen`); nonzero means a write.
- `wdata`  in  32  write data, already lane-aligned by the CPU (`m_data_wdata`).
- `rdata`  out  32  read data for `addr`, combinational.
- `irq`  out  1  interrupt request.

## Operation
- Hit when `addr[31:4] == BASE_ADDR[31:4]` and `addr[3:2] != 2'b11`. Offset +0 CTRL, +4 PRESET, +8 COUNT. Offset +C and all non-hits read 0 and ignore writes.
- CTRL fields: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, others behave as 00), [3] IM (interrupt mask), [31:4] read 0 and are not stored.
- Writes on a hit update only the bytes whose `byteen` bit is set. COUNT is read-only and ignores writes.
- A write to CTRL or PRESET clears the internal expiry flag `irq_flag`.
- FSM state is IDLE, LOAD, CNT or INT. State is internal; COUNT is the only observable.
- IDLE: if EN=1, go to LOAD.
- LOAD: COUNT <= PRESET; go to CNT.
- CNT: if EN=0, go to IDLE with COUNT held. Else if COUNT==0, go to INT. Else COUNT <= COUNT-1.
- INT, MODE 00: clear EN, set `irq_flag`, go to IDLE.
- INT, MODE 01: set `irq_flag` for that cycle only, go to LOAD.
- `irq` = IM & `irq_flag`.
  - One-shot: `irq_flag` holds until a CTRL/PRESET write.
  - Auto-reload: `irq_flag` clears on the cycle after INT, giving a 1-cycle pulse per period.
- COUNT arithmetic is unsigned 32-bit and never wraps below 0.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state IDLE, `irq_flag`=0, `irq`=0. `rdata` reflects these zeros.
- A write lands at the edge where `byteen` is sampled and is visible on `rdata` in the next cycle.
- With PRESET=N, EN is written at edge t0:
  - IDLE to LOAD at t1.
  - COUNT=N after t2.
  - COUNT=0 after t2+N.
  - INT after t3+N.
  - `irq` high after t4+N (if IM=1).
- PRESET=0: INT is reached one edge after LOAD.
- Simultaneous events:
  - A CPU write to CTRL in the INT cycle wins over the FSM's EN clear; `irq_flag` still sets.
  - A PRESET write during CNT does not affect the current COUNT; it is used at the next LOAD.
  - A CTRL write setting EN=0 during LOAD or INT takes effect from the following state: CNT or IDLE exits to IDLE. In auto-reload, INT to LOAD to CNT then exits.
- Asynchronous reset asserted mid-count returns to the reset values at once, with no pending `irq`.

## Configuration
- `TC_AUTO_RELOAD_EN` defined: MODE 01 behaves as auto-reload as above.
- Not defined: MODE bits are not stored and read 0, and every expiry is one-shot. Auto-reload logic is absent.

## Test plan
- Reset mid-count: with COUNT=5 in CNT, pulse `reset` low -> CTRL/PRESET/COUNT/`rdata`/`irq` all 0 immediately, state IDLE.
- One-shot: write PRESET=3, then CTRL=4'b1001 -> COUNT reads 3,2,1,0. `irq`=1 exactly 7 edges after the CTRL write and stays 1. CTRL reads 4'b1000. Writing CTRL=0 drops `irq` next cycle.
- Byte enable: with PRESET=0, write `addr`=BASE+4, `byteen`=4'b0100, `wdata`=32'h00AB_0000 -> PRESET reads 32'h00AB_0000. Write to BASE+8 -> COUNT unchanged. Read BASE+C -> 0.
- Auto-reload (`TC_AUTO_RELOAD_EN`): PRESET=2, CTRL=4'b1011 -> 1-cycle `irq` pulses every 5 cycles, EN stays 1. Same test without the macro -> single latched `irq`, CTRL reads 4'b1000.
- Mask and pause:
  - IM=0 run to expiry -> `irq`=0, then setting IM=1 via CTRL write -> `irq` stays 0 (flag cleared by the write).
  - EN=0 written in CNT at COUNT=4 -> COUNT holds 4, state IDLE.
- Non-hit: write `addr`=BASE+16, `byteen`=4'b1111 -> no register changes, `rdata`=0.
